// File: rtl/banco_registros_mp.sv
// Dual-write, multi-read register file with sequential clear FSM.
// Optional same-cycle write-to-read bypass: BANCO_REGISTROS_BYPASS_EN.
module banco_registros_mp #(
  parameter int LEN                  = 32,
  parameter int CANTIDAD_REGISTROS   = 32,
  parameter int NUM_READ             = 2,
  parameter int NB_ADDRESS_REGISTROS = $clog2(CANTIDAD_REGISTROS)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_clear,
  input  logic                                 i_read_en,
  input  logic [NUM_READ*NB_ADDRESS_REGISTROS-1:0] i_read_addr,
  output logic [NUM_READ*LEN-1:0]              o_read_data,
  input  logic                                 i_we_a,
  input  logic                                 i_we_b,
  input  logic [NB_ADDRESS_REGISTROS-1:0]      i_waddr_a,
  input  logic [NB_ADDRESS_REGISTROS-1:0]      i_waddr_b,
  input  logic [LEN-1:0]                       i_wdata_a,
  input  logic [LEN-1:0]                       i_wdata_b,
  input  logic [NB_ADDRESS_REGISTROS-1:0]      i_debug_addr,
  output logic [LEN-1:0]                       o_debug_data,
  output logic                                 o_busy
);

  localparam int NB = NB_ADDRESS_REGISTROS;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state_q, state_d;
  logic [NB-1:0]       cnt_q, cnt_d;
  logic [NUM_READ*LEN-1:0] rdata_q, rdata_d;
  logic [LEN-1:0]      mem_q [CANTIDAD_REGISTROS];
  logic [LEN-1:0]      mem_d [CANTIDAD_REGISTROS];

  logic run;
  logic we_a_ok;
  logic we_b_ok;

  assign run     = (state_q == RUN);
  assign we_a_ok = run && i_we_a && (i_waddr_a != '0);
  assign we_b_ok = run && i_we_b && (i_waddr_b != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == NB'(CANTIDAD_REGISTROS - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (i_clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Port B is applied last so it wins on an address collision.
  always_comb begin
    for (int i = 0; i < CANTIDAD_REGISTROS; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (!run) begin
      mem_d[cnt_q] = '0;
    end else begin
      if (we_a_ok) mem_d[i_waddr_a] = i_wdata_a;
      if (we_b_ok) mem_d[i_waddr_b] = i_wdata_b;
    end
  end

  always_comb begin
    logic [NB-1:0]  ra;
    logic [LEN-1:0] v;
    rdata_d = rdata_q;
    ra      = '0;
    v       = '0;
    if (!run) begin
      rdata_d = '0;
    end else if (i_read_en) begin
      for (int k = 0; k < NUM_READ; k++) begin
        ra = i_read_addr[k*NB +: NB];
        v  = (ra == '0) ? '0 : mem_q[ra];
`ifdef BANCO_REGISTROS_BYPASS_EN
        if (we_b_ok && (i_waddr_b == ra)) begin
          v = i_wdata_b;
        end else if (we_a_ok && (i_waddr_a == ra)) begin
          v = i_wdata_a;
        end
`endif
        rdata_d[k*LEN +: LEN] = v;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Array has no reset; a write coinciding with reset is dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < CANTIDAD_REGISTROS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign o_read_data  = rdata_q;
  assign o_busy       = !run;
  assign o_debug_data = (i_debug_addr == '0) ? '0 : mem_q[i_debug_addr];

endmodule

// File: tb/tb_banco_registros_mp.sv
// Directed testbench for banco_registros_mp (default parameters).
module tb_banco_registros_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        read_en;
  logic [9:0]  read_addr;
  logic [63:0] read_data;
  logic        we_a, we_b;
  logic [4:0]  waddr_a, waddr_b;
  logic [31:0] wdata_a, wdata_b;
  logic [4:0]  debug_addr;
  logic [31:0] debug_data;
  logic        busy;

  int vectors    = 0;
  int miscompares = 0;
  int n;
  logic [31:0] exp_byp;

  always #5 clk = ~clk;

  banco_registros_mp dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_clear      (clear),
    .i_read_en    (read_en),
    .i_read_addr  (read_addr),
    .o_read_data  (read_data),
    .i_we_a       (we_a),
    .i_we_b       (we_b),
    .i_waddr_a    (waddr_a),
    .i_waddr_b    (waddr_b),
    .i_wdata_a    (wdata_a),
    .i_wdata_b    (wdata_b),
    .i_debug_addr (debug_addr),
    .o_debug_data (debug_data),
    .o_busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; read_en = 1'b1; read_addr = '0;
    we_a = 1'b0; we_b = 1'b0; waddr_a = '0; waddr_b = '0;
    wdata_a = '0; wdata_b = '0; debug_addr = '0;
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_rdata", read_data, 64'd0);

    rst = 1'b0;
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    check("clear_len", 64'(n), 64'd32);
    for (int a = 0; a < 32; a++) begin
      debug_addr = 5'(a);
      #1;
      check($sformatf("dbg_zero_%0d", a), 64'(debug_data), 64'd0);
    end

    we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF;
    tick();
    we_a = 1'b0; read_addr = {5'd0, 5'd5};
    tick();
    check("rd_p0_a5", 64'(read_data[31:0]), 64'hDEADBEEF);

    read_addr = {5'd5, 5'd5};
    tick();
    check("same_addr", read_data, {32'hDEADBEEF, 32'hDEADBEEF});

    we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h11;
    we_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'h22;
    tick();
    we_b = 1'b0;
    debug_addr = 5'd7;
    #1;
    check("b_wins", 64'(debug_data), 64'h22);

    waddr_a = 5'd0; wdata_a = 32'hFF;
    tick();
    we_a = 1'b0; read_addr = {5'd0, 5'd0};
    tick();
    check("rd_zero", read_data, 64'd0);
    debug_addr = 5'd0;
    #1;
    check("dbg_zero", 64'(debug_data), 64'd0);

`ifdef BANCO_REGISTROS_BYPASS_EN
    exp_byp = 32'h55;
`else
    exp_byp = 32'h0;
`endif
    we_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'h55;
    read_addr = {5'd9, 5'd0};
    tick();
    we_a = 1'b0;
    check("bypass", 64'(read_data[63:32]), 64'(exp_byp));
    tick();
    check("rd_a9", 64'(read_data[63:32]), 64'h55);

    we_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'h1;
    tick();
    we_a = 1'b0; read_addr = {5'd0, 5'd3};
    tick();
    check("rd_a3", 64'(read_data[31:0]), 64'h1);
    read_en = 1'b0;
    we_a = 1'b1; wdata_a = 32'h2;
    tick();
    we_a = 1'b0;
    check("stall1", 64'(read_data[31:0]), 64'h1);
    tick();
    check("stall2", 64'(read_data[31:0]), 64'h1);
    tick();
    check("stall3", 64'(read_data[31:0]), 64'h1);
    debug_addr = 5'd3;
    #1;
    check("stall_wr", 64'(debug_data), 64'h2);
    read_en = 1'b1;
    tick();
    check("unstall", 64'(read_data[31:0]), 64'h2);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_busy", 64'(busy), 64'd1);
    we_a = 1'b1; waddr_a = 5'd2; wdata_a = 32'hAA;
    tick();
    check("clr_rdata", read_data, 64'd0);
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd1);
    tick();
    rst = 1'b0;
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    we_a = 1'b0;
    check("reclear_len", 64'(n), 64'd32);
    debug_addr = 5'd2;
    #1;
    check("clr_wr_lost", 64'(debug_data), 64'd0);
    debug_addr = 5'd5;
    #1;
    check("clr_a5", 64'(debug_data), 64'd0);
    debug_addr = 5'd9;
    #1;
    check("clr_a9", 64'(debug_data), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/banco_registros_mp.md
BANCO_REGISTROS_MP -- requirements
Module: banco_registros_mp

Interface
REQ-001 SHALL have parameter LEN, default 32: register width in bits.
REQ-002 SHALL have parameter CANTIDAD_REGISTROS, default 32: register count, power of two, at least 4.
REQ-003 SHALL have parameter NUM_READ, default 2, range 1-4: number of read ports.
REQ-004 SHALL have parameter NB_ADDRESS_REGISTROS, default $clog2(CANTIDAD_REGISTROS): address width.
REQ-005 SHALL have the following ports, clock and reset first; one clock; reset is asynchronous and active-high:
- i_clk  in  1  sole clock, rising edge
- i_rst  in  1  asynchronous reset, active-high
- i_clear  in  1  one-cycle pulse that starts a sequential clear
- i_read_en  in  1  read-register update enable (stall when 0)
- i_read_addr  in  NUM_READ*NB_ADDRESS_REGISTROS  packed read addresses; port k uses slice k
- o_read_data  out  NUM_READ*LEN  packed registered read data; port k uses slice k
- i_we_a, i_we_b  in  1 each  write enables
- i_waddr_a, i_waddr_b  in  NB_ADDRESS_REGISTROS each  write addresses
- i_wdata_a, i_wdata_b  in  LEN each  write data
- i_debug_addr  in  NB_ADDRESS_REGISTROS  debug address
- o_debug_data  out  LEN  combinational debug read of the array
- o_busy  out  1  high while the clear sequence is running

Function
REQ-006 SHALL implement FSM states CLEAR and RUN. Reset enters CLEAR with the clear counter at 0. In RUN, an i_clear pulse moves to CLEAR with the counter at 0. CLEAR moves to RUN after the clear write to address CANTIDAD_REGISTROS-1.
REQ-007 In CLEAR, SHALL write 0 to the register at the counter address and increment the counter each cycle; the clear SHALL take exactly CANTIDAD_REGISTROS cycles.
REQ-008 SHALL drive o_busy = 1 in CLEAR and 0 in RUN.
REQ-009 In CLEAR, SHALL ignore i_we_a and i_we_b, hold o_read_data at 0, and ignore i_clear.
REQ-010 Writes in RUN SHALL commit on the rising edge of i_clk.
REQ-011 When i_we_a and i_we_b target the same address in the same cycle, port B SHALL win.
REQ-012 Register 0 SHALL always read as 0; writes to address 0 SHALL be discarded.
REQ-013 Read latency SHALL be 1 cycle: on a rising edge with i_read_en = 1 in RUN, each o_read_data slice SHALL load the array value at its address.
REQ-014 With i_read_en = 0, o_read_data SHALL hold its value; writes SHALL still commit.
REQ-015 o_debug_data SHALL be a combinational read of the array at i_debug_addr (0 for address 0) and SHALL show the current array state, including during CLEAR.
REQ-016 Read ports SHALL be independent; equal addresses on several ports SHALL return identical data.

Reset
REQ-017 While i_rst = 1, SHALL asynchronously force o_read_data = 0, o_busy = 1, FSM = CLEAR and counter = 0.
REQ-018 The array SHALL NOT be asynchronously reset; after i_rst deasserts, the array SHALL be zeroed by the CLEAR sequence.
REQ-019 Reset asserted mid-CLEAR SHALL restart the clear from address 0.
REQ-020 Reset asserted mid-RUN SHALL discard any write in that cycle.

Configuration
REQ-021 Macro BANCO_REGISTROS_BYPASS_EN: when defined, a read port whose address equals a same-cycle enabled RUN write address (nonzero) SHALL load the write data (port B if both match). When undefined, the read SHALL load the pre-write array value; o_debug_data is unaffected either way.

Verification
REQ-022 Assert then release i_rst -> o_busy = 1 for exactly 32 cycles, then 0; o_debug_data = 0 for addresses 0..31.
REQ-023 In RUN, write A addr 5 = 0xDEADBEEF; next cycle read port0 addr 5 -> 0xDEADBEEF one cycle later.
REQ-024 Same cycle: i_we_a addr 7 = 0x11 and i_we_b addr 7 = 0x22 -> debug addr 7 = 0x22; write addr 0 = 0xFF -> read addr 0 returns 0.
REQ-025 Read port1 addr 9 while writing addr 9 = 0x55 (old value 0x0) -> 0x55 with BANCO_REGISTROS_BYPASS_EN defined, 0x0 without.
REQ-026 i_read_en = 0 for 3 cycles while addr 3 changes 0x1 -> 0x2 -> o_read_data holds 0x1; release -> 0x2 next edge.
REQ-027 i_clear at cycle 0, i_rst pulse at cycle 10 of the clear -> o_busy stays high 32 cycles after release; writes during CLEAR are lost.
